// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, forwarding and data-memory wait control for a 5-stage pipeline
//
// Optional feature: define PIPELINE_CTRL_TIMEOUT_EN to add an 8-bit memory-wait
// watchdog that sets the sticky mem_timeout flag and forces the FSM back to RUN.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   Rs1D, Rs2D                decode-stage source registers
//   Rs1E, Rs2E, RdE           execute-stage source/destination registers
//   ResultSrcE                execute-stage result select (01 = load)
//   PCSrcE                    taken branch/jump in execute
//   RdM, RegWriteM            memory-stage destination and write enable
//   RdW, RegWriteW            writeback-stage destination and write enable
//   MemReqM, mem_ready        memory-stage data access and its completion handshake
//   StallF/D/E/M              hold-enables for PC, F/D, D/E, E/M registers
//   FlushD/E/W                bubble-insert for D, E, W registers
//   ForwardAE, ForwardBE      ALU operand select (00 regfile, 01 W result, 10 ALUoutM)
//   stall_count               free-running count of memory-wait cycles
//   mem_timeout               sticky watchdog flag (tied 0 without the option)

module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        mem_ready,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic [31:0] stall_count,
  output logic        mem_timeout
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t state;
  logic   mem_wait;
  logic   lw_stall;

  // A miss stalls in the very cycle it is seen, so the RUN term is needed; the
  // cycle mem_ready rises is an ordinary RUN cycle (no added latency on a hit).
  assign mem_wait = !mem_ready &&
                    ((state == MEM_WAIT) || (state == RUN && MemReqM));

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
      fwd_sel = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
      fwd_sel = 2'b01;
    else
      fwd_sel = 2'b00;
  endfunction

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
      if (mem_wait) begin
        // Freeze everything up to M; W gets a bubble so no stale writeback repeats.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        // A redirect discards the dependent instruction, so it overrides the load-use stall.
        StallF = lw_stall && !PCSrcE;
        StallD = lw_stall && !PCSrcE;
        FlushD = PCSrcE;
        FlushE = PCSrcE || lw_stall;
      end
    end
  end

`ifdef PIPELINE_CTRL_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      stall_count <= 32'd0;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      if (mem_wait)
        stall_count <= stall_count + 32'd1;
      case (state)
        RUN: begin
          if (MemReqM && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= RUN;
          end else if (wait_cnt == 8'd255) begin
            mem_timeout <= 1'b1;
            state       <= RUN;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
`else
  assign mem_timeout = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      stall_count <= 32'd0;
    end else begin
      if (mem_wait)
        stall_count <= stall_count + 32'd1;
      case (state)
        RUN:      if (MemReqM && !mem_ready) state <= MEM_WAIT;
        MEM_WAIT: if (mem_ready) state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end
`endif

endmodule
